// File: rtl/clock_switch_pkg.sv
// Shared types and helpers for the glitch-free divided-clock switch.
// Ratios below MIN_DIV are forced up so every period has a high and a low phase.
package clock_switch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend,
        StPark
    } sw_state_e;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

    // Odd ratios put the extra cycle in the low phase.
    function automatic logic [31:0] half_div(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/div_phase_counter.sv
// Phase counter for one divided-clock period plus the registered high flag that forms clk_out.
// hold freezes the phase and forces the output low; load restarts the phase at 0.
module div_phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ratio,
    input  logic             load,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             boundary,
    output logic             high
);
    import clock_switch_pkg::*;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] half;
    logic             high_q;

    assign half     = CNT_W'(half_div(32'(ratio)));
    assign boundary = (count_q == ratio - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            high_q  <= 1'b0;
        end else if (load) begin
            count_q <= '0;
            high_q  <= 1'b0;
        end else if (hold) begin
            high_q  <= 1'b0;
        end else begin
            high_q  <= (count_q < half);
            count_q <= boundary ? '0 : count_q + CNT_W'(1);
        end
    end

    assign count = count_q;
    assign high  = high_q;

endmodule

// File: rtl/clock_div_switch.sv
// Glitch-free switch between NUM_SEL programmable divide ratios of clk.
// Switches take effect only at a period boundary, followed by DEAD_CYC forced-low cycles.
module clock_div_switch
    import clock_switch_pkg::*;
#(
    parameter int unsigned NUM_SEL  = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SEL*CNT_W-1:0]   div_tab,
    input  logic                       en,
    input  logic                       sw_req,
    input  logic [$clog2(NUM_SEL)-1:0] sw_sel,
    output logic                       clk_out,
    output logic                       clk_en,
    output logic [$clog2(NUM_SEL)-1:0] cur_sel,
    output logic                       busy,
    output logic                       sw_done,
    output logic                       sw_drop
);

    localparam int unsigned SEL_W  = $clog2(NUM_SEL);
    localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DEAD_W-1:0] DEAD_INIT = (DEAD_CYC > 0) ? DEAD_W'(DEAD_CYC - 1) : '0;

    sw_state_e         state_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [SEL_W-1:0]  tgt_q;
    logic [CNT_W-1:0]  ratio_q;
    logic [DEAD_W-1:0] dead_q;
    logic              busy_q;
    logic              sw_done_q;
    logic              sw_drop_q;
    logic              clk_en_q;

    logic [CNT_W-1:0]  tab_ratio [NUM_SEL];
    logic [CNT_W-1:0]  count;
    logic              boundary;
    logic              run_phase;
    logic              complete;

    for (genvar i = 0; i < NUM_SEL; i++) begin : g_tab
        assign tab_ratio[i] = CNT_W'(clamp_div(32'(div_tab[i*CNT_W +: CNT_W])));
    end

    assign run_phase = (state_q == StRun) || (state_q == StPend);
    // With no dead time the pending switch lands directly on the boundary.
    assign complete  = ((state_q == StPend) && boundary && (DEAD_CYC == 0)) ||
                       ((state_q == StPark) && (dead_q == '0));

    div_phase_counter #(
        .CNT_W    (CNT_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .ratio    (ratio_q),
        .load     (complete),
        .hold     (!run_phase),
        .count    (count),
        .boundary (boundary),
        .high     (clk_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StRun;
            cur_sel_q <= '0;
            tgt_q     <= '0;
            ratio_q   <= tab_ratio[0];
            dead_q    <= '0;
            busy_q    <= 1'b0;
            sw_done_q <= 1'b0;
            sw_drop_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            sw_done_q <= 1'b0;
            sw_drop_q <= 1'b0;
            clk_en_q  <= run_phase && (count == '0);

            unique case (state_q)
                StIdle: begin
                    if (sw_req) begin
                        sw_done_q <= 1'b1;
                        if (sw_sel != cur_sel_q) begin
                            cur_sel_q <= sw_sel;
                            ratio_q   <= tab_ratio[sw_sel];
                        end
                    end
                    if (en) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (sw_req && (sw_sel != cur_sel_q)) begin
                        tgt_q   <= sw_sel;
                        busy_q  <= 1'b1;
                        state_q <= StPend;
                    end else begin
                        if (sw_req) begin
                            sw_done_q <= 1'b1;
                        end
                        if (boundary && !en) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StPend: begin
                    if (sw_req) begin
                        sw_drop_q <= 1'b1;
                    end
                    if (boundary && !complete) begin
                        state_q <= StPark;
                        dead_q  <= DEAD_INIT;
                    end
                end
                StPark: begin
                    if (sw_req) begin
                        sw_drop_q <= 1'b1;
                    end
                    if (!complete) begin
                        dead_q <= dead_q - DEAD_W'(1);
                    end
                end
                default: state_q <= StRun;
            endcase

            if (complete) begin
                cur_sel_q <= tgt_q;
                ratio_q   <= tab_ratio[tgt_q];
                sw_done_q <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= en ? StRun : StIdle;
            end
        end
    end

    assign clk_en  = clk_en_q;
    assign cur_sel = cur_sel_q;
    assign busy    = busy_q;
    assign sw_done = sw_done_q;
    assign sw_drop = sw_drop_q;

endmodule
